// File: rtl/audio_pkg.sv
// Shared note and sequencer types for the AudioController note path.
// ARTIC_GAP_EN adds a silent GAP state after every played note.
package audio_pkg;

    localparam int TONE_W = 6;
    localparam int VOL_W  = 4;
    localparam int DUR_W  = 6;
    localparam int NOTE_W = DUR_W + VOL_W + TONE_W;

    typedef struct packed {
        logic [DUR_W-1:0]  dur;
        logic [VOL_W-1:0]  vol;
        logic [TONE_W-1:0] tone;
    } note_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
`ifdef ARTIC_GAP_EN
        ,
        S_GAP  = 2'd3
`endif
    } seq_state_t;

    function automatic logic dur_zero(input note_t n);
        return n.dur == '0;
    endfunction

endpackage

// File: rtl/note_fifo.sv
// Synchronous note queue; flush wins over push/pop, push ignored while full.
module note_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  note_t                    i_wdata,
    output note_t                    o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    note_t            r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_rdata = r_mem[r_rd];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Plays queued notes into the tone generator (TONE/VOL/EN) for DUR ticks each.
// Define ARTIC_GAP_EN to insert GAP_TICKS of silence after every note.
module note_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int TICK_DIV   = 1_000_000,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_TICKS  = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] NOTE_IN,
    input  logic        NOTE_VALID,
    output logic        NOTE_READY,
    input  logic        START,
    input  logic        STOP,
    input  logic        PAUSE,
    output logic [5:0]  TONE,
    output logic [3:0]  VOL,
    output logic        EN,
    output logic        BUSY,
    output logic        DONE
);

    // Falls back to a 1-bit prescaler on nonsensical configurations.
    localparam int PW = (TICK_DIV >= 2 && CLK_FREQ > 0 && GAP_TICKS > 0)
                        ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);

    seq_state_t          r_state;
    seq_state_t          w_next;
    seq_state_t          w_after;
    logic [TONE_W-1:0]   r_tone;
    logic [VOL_W-1:0]    r_vol;
    logic [DUR_W-1:0]    r_dur;
    logic [PW-1:0]       r_ps;
    logic                r_done;
    logic                r_alive;

    note_t               w_in;
    note_t               w_head;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_more;
    logic                w_more_load;
    logic                w_tick_end;
    logic                w_run;
    logic                w_note_end;

    assign w_in        = NOTE_IN;
    assign NOTE_READY  = r_alive && !w_full;
    assign w_push      = NOTE_VALID && NOTE_READY && !STOP;
    assign w_pop       = (r_state == S_LOAD) && !STOP;
    assign w_more      = !w_empty || w_push;
    assign w_more_load = (w_count > CW'(1)) || w_push;
    assign w_tick_end  = (r_ps == PS_MAX);
    assign w_note_end  = (r_state == S_PLAY) && !PAUSE && w_tick_end
                         && (r_dur == DUR_W'(1));
    assign DONE        = r_done;

    note_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (STOP),
        .i_wdata (w_in),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef ARTIC_GAP_EN
    localparam int GW = $clog2(GAP_TICKS + 1);

    logic [GW-1:0]       r_gap;
    logic                w_gap_end;
    seq_state_t          w_after_gap;

    assign w_run       = (r_state == S_PLAY || r_state == S_GAP) && !PAUSE;
    assign w_gap_end   = (r_state == S_GAP) && !PAUSE && w_tick_end
                         && (r_gap == GW'(1));
    assign w_after     = S_GAP;
    assign w_after_gap = w_more ? S_LOAD : S_IDLE;
`else
    assign w_run       = (r_state == S_PLAY) && !PAUSE;
    assign w_after     = w_more ? S_LOAD : S_IDLE;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (STOP) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (START && !w_empty) w_next = S_LOAD;
                end
                S_LOAD: begin
                    if (!dur_zero(w_head)) w_next = S_PLAY;
                    else if (w_more_load)  w_next = S_LOAD;
                    else                   w_next = S_IDLE;
                end
                S_PLAY: begin
                    if (w_note_end) w_next = w_after;
                end
`ifdef ARTIC_GAP_EN
                S_GAP: begin
                    if (w_gap_end) w_next = w_after_gap;
                end
`endif
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tone  <= '0;
            r_vol   <= '0;
            r_dur   <= '0;
            r_ps    <= '0;
            r_done  <= 1'b0;
            r_alive <= 1'b0;
`ifdef ARTIC_GAP_EN
            r_gap   <= '0;
`endif
        end else begin
            r_alive <= 1'b1;
            r_done  <= !STOP && (r_state != S_IDLE) && (w_next == S_IDLE);
            if (r_state == S_LOAD && !dur_zero(w_head)) begin
                r_tone <= w_head.tone;
                r_vol  <= w_head.vol;
                r_dur  <= w_head.dur;
                r_ps   <= '0;
            end else if (w_run) begin
                r_ps <= w_tick_end ? '0 : r_ps + 1'b1;
                if (w_tick_end && r_state == S_PLAY && r_dur != '0) begin
                    r_dur <= r_dur - 1'b1;
                end
`ifdef ARTIC_GAP_EN
                if (w_note_end) begin
                    r_gap <= GW'(GAP_TICKS);
                end else if (w_tick_end && r_state == S_GAP
                             && r_gap != '0) begin
                    r_gap <= r_gap - 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        EN   = 1'b0;
        TONE = '0;
        VOL  = '0;
        BUSY = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                EN = 1'b0;
            end
            S_LOAD: begin
                TONE = r_tone;
                VOL  = r_vol;
            end
            S_PLAY: begin
                TONE = r_tone;
                VOL  = r_vol;
                EN   = !PAUSE;
            end
`ifdef ARTIC_GAP_EN
            S_GAP: begin
                TONE = r_tone;
                VOL  = r_vol;
            end
`endif
            default: EN = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer against a timeline model of playback.
// Expected segment start/length values come from walking the queued note list.
module tb_note_sequencer;

    localparam int TD    = 4;
    localparam int DEPTH = 8;
    localparam int GT    = 1;
`ifdef ARTIC_GAP_EN
    localparam int GAPC  = GT * TD;
`else
    localparam int GAPC  = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [15:0] NOTE_IN = '0;
    logic        NOTE_VALID = 1'b0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        PAUSE = 1'b0;
    logic        NOTE_READY;
    logic [5:0]  TONE;
    logic [3:0]  VOL;
    logic        EN;
    logic        BUSY;
    logic        DONE;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] model_q[$];
    int          exp_start[$];
    int          exp_len[$];
    logic [5:0]  exp_tone[$];
    logic [3:0]  exp_vol[$];
    int          exp_done;

    int          seg_start[$];
    int          seg_len[$];
    logic [5:0]  seg_tone[$];
    logic [3:0]  seg_vol[$];
    int          done_k;
    int          glitch;
    logic        busy_at_done;
    logic        done_after;

    always #5 CLK = ~CLK;

    note_sequencer #(
        .CLK_FREQ   (100_000_000),
        .TICK_DIV   (TD),
        .FIFO_DEPTH (DEPTH),
        .GAP_TICKS  (GT)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .NOTE_IN    (NOTE_IN),
        .NOTE_VALID (NOTE_VALID),
        .NOTE_READY (NOTE_READY),
        .START      (START),
        .STOP       (STOP),
        .PAUSE      (PAUSE),
        .TONE       (TONE),
        .VOL        (VOL),
        .EN         (EN),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] mk(input int d, input int v, input int t);
        logic [5:0] dd = d[5:0];
        logic [3:0] vv = v[3:0];
        logic [5:0] tt = t[5:0];
        return {dd, vv, tt};
    endfunction

    task automatic push_note(input logic [15:0] n);
        if (model_q.size() < DEPTH) model_q.push_back(n);
        NOTE_IN = n;
        NOTE_VALID = 1'b1;
        tick();
        NOTE_VALID = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the START edge; each note costs one
    // LOAD cycle, then DUR*TD playing cycles (plus the gap when enabled).
    task automatic build_expected();
        int k = 1;
        exp_start.delete();
        exp_len.delete();
        exp_tone.delete();
        exp_vol.delete();
        foreach (model_q[i]) begin
            int d = int'(model_q[i][15:10]);
            k++;
            if (d != 0) begin
                exp_start.push_back(k);
                exp_len.push_back(d * TD);
                exp_tone.push_back(model_q[i][5:0]);
                exp_vol.push_back(model_q[i][9:6]);
                k += d * TD + GAPC;
            end
        end
        exp_done = k;
        model_q.delete();
    endtask

    task automatic capture(input int maxc);
        logic prev_en = 1'b0;
        int   last;
        seg_start.delete();
        seg_len.delete();
        seg_tone.delete();
        seg_vol.delete();
        done_k = 0;
        glitch = 0;
        busy_at_done = 1'b1;
        done_after = 1'b0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 1; k <= maxc; k++) begin
            if (EN) begin
                if (!prev_en) begin
                    seg_start.push_back(k);
                    seg_len.push_back(0);
                    seg_tone.push_back(TONE);
                    seg_vol.push_back(VOL);
                end
                last = seg_len.size() - 1;
                seg_len[last] = seg_len[last] + 1;
                if (TONE !== seg_tone[last] || VOL !== seg_vol[last]) glitch++;
            end
            if (DONE) begin
                done_k = k;
                busy_at_done = BUSY;
                break;
            end
            prev_en = EN;
            tick();
        end
        if (done_k != 0) begin
            tick();
            done_after = DONE;
        end
    endtask

    task automatic test_reset();
        #2 RST_N = 1'b0;
        #2;
        n_total++;
        if (EN !== 1'b0) $display("FAIL reset_en: got %0d want 0", EN);
        else n_pass++;
        n_total++;
        if (TONE !== 6'd0 || VOL !== 4'd0)
            $display("FAIL reset_tone_vol: got %0d/%0d want 0/0", TONE, VOL);
        else n_pass++;
        n_total++;
        if (BUSY !== 1'b0 || DONE !== 1'b0)
            $display("FAIL reset_busy_done: got %0d/%0d want 0/0", BUSY, DONE);
        else n_pass++;
        n_total++;
        if (NOTE_READY !== 1'b0) $display("FAIL reset_ready: got %0d want 0", NOTE_READY);
        else n_pass++;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        tick();
        n_total++;
        if (NOTE_READY !== 1'b1 || BUSY !== 1'b0)
            $display("FAIL post_reset: got ready=%0d busy=%0d want 1/0", NOTE_READY, BUSY);
        else n_pass++;
    endtask

    task automatic test_basic();
        push_note(mk(2, 8, 12));
        build_expected();
        capture(200);
        n_total++;
        if (seg_start.size() != 1)
            $display("FAIL basic_segs: got %0d want 1", seg_start.size());
        else begin
            n_pass++;
            n_total++;
            if (seg_start[0] != 2) $display("FAIL basic_start: got %0d want 2", seg_start[0]);
            else n_pass++;
            n_total++;
            if (seg_len[0] != 2 * TD) $display("FAIL basic_len: got %0d want %0d", seg_len[0], 2 * TD);
            else n_pass++;
            n_total++;
            if (seg_tone[0] !== 6'd12 || seg_vol[0] !== 4'd8)
                $display("FAIL basic_tone_vol: got %0d/%0d want 12/8", seg_tone[0], seg_vol[0]);
            else n_pass++;
        end
        n_total++;
        if (done_k != exp_done) $display("FAIL basic_done: got %0d want %0d", done_k, exp_done);
        else n_pass++;
        n_total++;
        if (busy_at_done !== 1'b0 || done_after !== 1'b0)
            $display("FAIL basic_busy_pulse: got busy=%0d next_done=%0d want 0/0", busy_at_done, done_after);
        else n_pass++;
    endtask

    task automatic test_zero_dur();
        push_note(mk(0, 3, 5));
        push_note(mk(1, 6, 7));
        build_expected();
        capture(200);
        n_total++;
        if (seg_start.size() != 1)
            $display("FAIL zero_segs: got %0d want 1", seg_start.size());
        else begin
            n_pass++;
            n_total++;
            if (seg_tone[0] !== 6'd7 || seg_len[0] != TD || seg_start[0] != 3)
                $display("FAIL zero_play: got tone=%0d len=%0d start=%0d want 7/%0d/3", seg_tone[0], seg_len[0], seg_start[0], TD);
            else n_pass++;
        end
        n_total++;
        if (done_k != exp_done) $display("FAIL zero_done: got %0d want %0d", done_k, exp_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gap;
        push_note(mk(1, 2, 3));
        push_note(mk(1, 4, 5));
        model_q.delete();
        capture(200);
        n_total++;
        if (seg_start.size() != 2)
            $display("FAIL b2b_segs: got %0d want 2", seg_start.size());
        else begin
            n_pass++;
            gap = seg_start[1] - (seg_start[0] + seg_len[0]);
            n_total++;
            if (gap != GAPC + 1) $display("FAIL b2b_gap: got %0d want %0d", gap, GAPC + 1);
            else n_pass++;
            n_total++;
            if (seg_tone[1] !== 6'd5 || seg_len[1] != TD)
                $display("FAIL b2b_second: got tone=%0d len=%0d want 5/%0d", seg_tone[1], seg_len[1], TD);
            else n_pass++;
        end
    endtask

    task automatic test_full();
        for (int i = 0; i <= DEPTH; i++) begin
            n_total++;
            if (NOTE_READY !== (i < DEPTH))
                $display("FAIL full_ready_%0d: got %0d want %0d", i, NOTE_READY, i < DEPTH);
            else n_pass++;
            push_note(mk($urandom_range(1, 3), $urandom_range(0, 15), $urandom_range(0, 63)));
        end
        n_total++;
        if (model_q.size() != DEPTH) $display("FAIL full_model: got %0d want %0d", model_q.size(), DEPTH);
        else n_pass++;
        build_expected();
        capture(3000);
        n_total++;
        if (seg_start.size() != exp_start.size())
            $display("FAIL full_segs: got %0d want %0d", seg_start.size(), exp_start.size());
        else begin
            n_pass++;
            foreach (exp_start[i]) begin
                n_total++;
                if (seg_start[i] != exp_start[i] || seg_len[i] != exp_len[i]
                    || seg_tone[i] !== exp_tone[i] || seg_vol[i] !== exp_vol[i])
                    $display("FAIL full_seg%0d: got s%0d l%0d t%0d v%0d want s%0d l%0d t%0d v%0d", i,
                             seg_start[i], seg_len[i], seg_tone[i], seg_vol[i],
                             exp_start[i], exp_len[i], exp_tone[i], exp_vol[i]);
                else n_pass++;
            end
        end
        n_total++;
        if (done_k != exp_done) $display("FAIL full_done: got %0d want %0d", done_k, exp_done);
        else n_pass++;
    endtask

    task automatic test_pause();
        int en_hi = 0;
        int lo_p = 0;
        int dk = 0;
        logic [5:0] tp = '0;
        push_note(mk(3, 9, 33));
        model_q.delete();
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            PAUSE = (k >= 4 && k < 14);
            #1;
            if (EN) en_hi++;
            if (PAUSE && !EN) lo_p++;
            if (k == 8) tp = TONE;
            if (DONE) begin
                dk = k;
                break;
            end
            tick();
        end
        PAUSE = 1'b0;
        n_total++;
        if (lo_p != 10) $display("FAIL pause_low: got %0d want 10", lo_p);
        else n_pass++;
        n_total++;
        if (en_hi != 3 * TD) $display("FAIL pause_en_total: got %0d want %0d", en_hi, 3 * TD);
        else n_pass++;
        n_total++;
        if (tp !== 6'd33) $display("FAIL pause_tone_held: got %0d want 33", tp);
        else n_pass++;
        n_total++;
        if (dk != 2 + 3 * TD + 10 + GAPC) $display("FAIL pause_done: got %0d want %0d", dk, 2 + 3 * TD + 10 + GAPC);
        else n_pass++;
        tick();
    endtask

    task automatic test_stop();
        int dones = 0;
        push_note(mk(3, 5, 9));
        push_note(mk(3, 6, 10));
        push_note(mk(3, 7, 11));
        model_q.delete();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (4) tick();
        n_total++;
        if (EN !== 1'b1) $display("FAIL stop_playing: got %0d want 1", EN);
        else n_pass++;
        STOP = 1'b1;
        NOTE_IN = mk(2, 1, 1);
        NOTE_VALID = 1'b1;
        tick();
        STOP = 1'b0;
        NOTE_VALID = 1'b0;
        n_total++;
        if (BUSY !== 1'b0 || EN !== 1'b0 || DONE !== 1'b0)
            $display("FAIL stop_idle: got busy=%0d en=%0d done=%0d want 0/0/0", BUSY, EN, DONE);
        else n_pass++;
        n_total++;
        if (TONE !== 6'd0 || VOL !== 4'd0) $display("FAIL stop_outputs: got %0d/%0d want 0/0", TONE, VOL);
        else n_pass++;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (BUSY || EN || DONE) dones++;
            tick();
        end
        n_total++;
        if (dones != 0) $display("FAIL stop_flushed: got %0d active cycles want 0", dones);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        push_note(mk(5, 3, 20));
        model_q.delete();
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (4) tick();
        n_total++;
        if (EN !== 1'b1) $display("FAIL rstmid_playing: got %0d want 1", EN);
        else n_pass++;
        #2 RST_N = 1'b0;
        #1;
        n_total++;
        if (EN !== 1'b0 || TONE !== 6'd0 || BUSY !== 1'b0 || NOTE_READY !== 1'b0)
            $display("FAIL rstmid_drop: got en=%0d tone=%0d busy=%0d ready=%0d want 0", EN, TONE, BUSY, NOTE_READY);
        else n_pass++;
        tick();
        RST_N = 1'b1;
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        n_total++;
        if (BUSY !== 1'b0) $display("FAIL rstmid_queue_lost: got busy=%0d want 0", BUSY);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int n = $urandom_range(1, DEPTH);
            for (int j = 0; j < n; j++)
                push_note(mk($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 63)));
            build_expected();
            capture(3000);
            n_total++;
            if (seg_start.size() != exp_start.size())
                $display("FAIL rand%0d_segs: got %0d want %0d", it, seg_start.size(), exp_start.size());
            else begin
                n_pass++;
                foreach (exp_start[i]) begin
                    n_total++;
                    if (seg_start[i] != exp_start[i] || seg_len[i] != exp_len[i]
                        || seg_tone[i] !== exp_tone[i] || seg_vol[i] !== exp_vol[i])
                        $display("FAIL rand%0d_seg%0d: got s%0d l%0d t%0d v%0d want s%0d l%0d t%0d v%0d", it, i,
                                 seg_start[i], seg_len[i], seg_tone[i], seg_vol[i],
                                 exp_start[i], exp_len[i], exp_tone[i], exp_vol[i]);
                    else n_pass++;
                end
            end
            n_total++;
            if (done_k != exp_done || glitch != 0 || busy_at_done !== 1'b0)
                $display("FAIL rand%0d_done: got k=%0d glitch=%0d busy=%0d want k=%0d 0 0", it, done_k, glitch, busy_at_done, exp_done);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_dur();
        test_back_to_back();
        test_full();
        test_pause();
        test_stop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a queued list of notes by driving the tone generator's TONE, VOL and EN inputs. A host pushes notes into an internal FIFO with a valid/ready handshake. On START the block plays each note for its programmed duration, measured in prescaled ticks. It sits between the control/CPU interface and the tone generator in the AudioController path.

## Interface
- CLK_FREQ, 100_000_000, system clock in Hz (documentation only; not used arithmetically)
- TICK_DIV, 1_000_000, CLK cycles per duration tick (10 ms at 100 MHz); must be ≥2
- FIFO_DEPTH, 8, note queue depth; power of 2, ≥2
- GAP_TICKS, 1, ticks of silence between notes (used only with ARTIC_GAP_EN)

Ports:
- CLK  in  1  system clock, 100 MHz
- RST_N  in  1  asynchronous active-low reset
- NOTE_IN  in  16  {DUR[15:10], VOL[9:6], TONE[5:0]}; DUR in ticks
- NOTE_VALID  in  1  NOTE_IN valid
- NOTE_READY  out  1  FIFO not full
- START  in  1  single-cycle pulse: begin playback
- STOP  in  1  single-cycle pulse: abort and flush
- PAUSE  in  1  level: freeze playback
- TONE  out  6  tone code to the tone generator
- VOL  out  4  volume to the tone generator
- EN  out  1  tone generator enable
- BUSY  out  1  state ≠ IDLE
- DONE  out  1  one-cycle pulse when the queue drains naturally

## Operation
- Push: a note is pushed when NOTE_VALID && NOTE_READY. NOTE_READY = !full. While full, NOTE_VALID is ignored and no data is lost or overwritten.
- States: IDLE, LOAD, PLAY, GAP (GAP exists only with the macro).
- IDLE: EN=0, TONE=0, VOL=0.
  - START with the FIFO non-empty → LOAD.
  - START with the FIFO empty is ignored.
- LOAD (one cycle): pop the FIFO head.
  - DUR=0: note is discarded. Go to LOAD again if the FIFO is still non-empty; otherwise go to IDLE and pulse DONE.
  - DUR≠0: latch TONE/VOL, dur_cnt←DUR, prescaler←0 → PLAY.
  - EN=0 during LOAD.
- PLAY: EN=1 and TONE/VOL held.
  - Prescaler counts 0..TICK_DIV-1. At TICK_DIV-1, dur_cnt decrements.
  - When dur_cnt reaches 0, the next state is GAP (macro on), or LOAD (FIFO non-empty) / IDLE with DONE pulse (FIFO empty).
  - TONE=0 (rest) plays normally; the tone generator silences itself.
- PAUSE=1 in PLAY/GAP: prescaler and dur_cnt frozen, EN=0, TONE/VOL held. Counting resumes exactly where it stopped when PAUSE falls. PAUSE has no effect in IDLE or LOAD.
- STOP in any state:
  - Next state IDLE, FIFO flushed, EN/TONE/VOL=0, no DONE.
  - STOP beats START and any push in the same cycle (that push is dropped).
- A push during PLAY is allowed. A note pushed while the FIFO is non-empty is always played in the same run.
- Arithmetic: prescaler is $clog2(TICK_DIV) bits; dur_cnt is 6 bits and never underflows. FIFO pointers wrap modulo FIFO_DEPTH, with a count register of $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset (async assert, sync release): TONE=0, VOL=0, EN=0, BUSY=0, DONE=0, NOTE_READY=0 while RST_N=0. FIFO empty, state IDLE.
- Reset mid-note: outputs drop immediately and the queue is lost.
- START at cycle t → LOAD at t+1 → EN=1 with valid TONE/VOL at t+2.
- A note with DUR=D holds EN=1 for exactly D×TICK_DIV cycles, excluding paused cycles.
- Between back-to-back notes, EN is low for 1 cycle (LOAD), or GAP_TICKS×TICK_DIV+1 cycles with the macro.
- DONE asserts in the cycle the state returns to IDLE from PLAY/GAP/LOAD. BUSY falls in that same cycle.
- A push becomes visible to LOAD one cycle after the handshake.

## Configuration
- ARTIC_GAP_EN defined: after each PLAY, enter GAP for GAP_TICKS ticks with EN=0 and TONE/VOL held, then go to LOAD or IDLE. This gives audible separation of repeated notes.
- ARTIC_GAP_EN undefined: the GAP state and its counter are absent, and PLAY goes directly to LOAD/IDLE.

## Structure
- Shared package audio_pkg:
  - note_t packed struct {dur[5:0], vol[3:0], tone[5:0]}
  - seq_state_t enum
  - TONE_W=6, VOL_W=4, DUR_W=6
- Sub-module note_fifo: synchronous FIFO, parameter DEPTH, ports for push/pop/flush, full/empty.

## Test plan
- Reset, then push {DUR=2, VOL=8, TONE=12} with TICK_DIV=4, then START → EN high from t+2 for exactly 8 cycles, TONE=12, VOL=8, then DONE pulse and BUSY=0.
- Push 8 notes with FIFO_DEPTH=8, then attempt a 9th push → NOTE_READY=0 and the 9th is not stored; START plays exactly 8 notes in order.
- Queue of {DUR=0, TONE=5}, {DUR=1, TONE=7}, then START → TONE=5 never appears on EN=1; TONE=7 plays for TICK_DIV cycles.
- PAUSE high for 10 cycles mid-note (DUR=3, TICK_DIV=4) → EN low for those 10 cycles; total EN-high cycles still equal 12.
- STOP mid-PLAY with 3 notes queued, plus a simultaneous push → next cycle IDLE, EN=0, no DONE; a later START is ignored because the FIFO is empty.
- Macro on, GAP_TICKS=1, TICK_DIV=4, two DUR=1 notes → EN low for exactly 5 cycles between the notes.
